// File: rtl/adder_pkg.sv
// Shared constants, payload types and packed-slice helpers for the arbitrated adder.
package adder_pkg;

  localparam int unsigned ADD_W = 32;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             cin;
  } add_op_t;

  typedef struct packed {
    logic [ADD_W-1:0] sum;
    logic             cout;
  } add_res_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of requester idx inside a packed operand bus.
  function automatic int unsigned slice_lo(input int unsigned idx);
    return idx * ADD_W;
  endfunction

endpackage

// File: rtl/adder_arbiter_add32.sv
// The shared 32-bit adder: sum and carry-out of a + b + cin.
module adder_arbiter_add32
  import adder_pkg::*;
(
  input  add_op_t  op,
  output add_res_t res_c
);

  logic [ADD_W:0] full;

  assign full       = {1'b0, op.a} + {1'b0, op.b} + (ADD_W+1)'(op.cin);
  assign res_c.sum  = full[ADD_W-1:0];
  assign res_c.cout = full[ADD_W];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among N_REQ requesters,
// with a single registered result slot that supports one op per cycle.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [$clog2(N_REQ)-1:0] rsp_id
);

  localparam int unsigned ID_W = id_w(N_REQ);

  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic [N_REQ-1:0] grant_oh;
  logic             can_accept;
  logic             req_hs;
  int unsigned      idx;
  add_op_t          op;
  add_res_t         res;

  // Round-robin search starting at ptr_q, first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign grant_oh   = found ? (N_REQ'(1) << winner) : '0;
  assign can_accept = !rsp_valid || rsp_ready;
  // Ready depends only on valids, pointer and result slot; never on operands.
  assign req_ready  = (rst_n && can_accept) ? grant_oh : '0;
  assign req_hs     = |(req_valid & req_ready);

  // One-hot AND-OR operand mux into the single adder.
  always_comb begin
    op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      op.a   = op.a | ({ADD_W{grant_oh[i]}} & req_a[slice_lo(i) +: ADD_W]);
      op.b   = op.b | ({ADD_W{grant_oh[i]}} & req_b[slice_lo(i) +: ADD_W]);
      op.cin = op.cin | (grant_oh[i] & req_cin[i]);
    end
  end

  adder_arbiter_add32 u_add (
    .op    (op),
    .res_c (res)
  );

  // Result slot and pointer; a handshake reloads even while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      ptr_q     <= '0;
    end else if (req_hs) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= res.sum;
      rsp_cout  <= res.cout;
      rsp_id    <= winner;
      ptr_q     <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vectors with literal expectations plus a
// cycle-level reference model compared on every clock.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_cin = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the result slot as the bench expects it, plus a
  // round-robin pointer kept as a plain integer.
  bit           m_valid, n_valid;
  logic [W-1:0] m_sum, n_sum;
  bit           m_cout, n_cout;
  int           m_id, n_id, m_ptr, n_ptr;
  int           waitc [N];
  logic [N-1:0] last_hs;
  int           w;
  bit           can;
  logic [N-1:0] er;
  logic [W:0]   full;

  always @(posedge clk or negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_sum = '0; m_cout = 0; m_id = 0; m_ptr = 0;
      n_valid = 0; n_sum = '0; n_cout = 0; n_id = 0; n_ptr = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      last_hs = '0;
    end else if (clk) begin
      m_valid = n_valid; m_sum = n_sum; m_cout = n_cout; m_id = n_id; m_ptr = n_ptr;
    end else begin
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_cout", rsp_cout, m_cout);
      chk("rsp_id", rsp_id, m_id);
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      can = !m_valid || rsp_ready;
      er = (w >= 0 && can) ? (N'(1) << w) : '0;
      chk("req_ready", req_ready, er);
      last_hs = er;
      n_valid = m_valid; n_sum = m_sum; n_cout = m_cout; n_id = m_id; n_ptr = m_ptr;
      if (w >= 0 && can) begin
        full = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]} + (W+1)'(req_cin[w]);
        n_valid = 1; n_sum = full[W-1:0]; n_cout = full[W]; n_id = w;
        n_ptr = (w + 1) % N;
        chk("starvation", waitc[w] < N, 1);
        waitc[w] = 0;
      end else if (m_valid && rsp_ready) begin
        n_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) waitc[i] = 0;
        else if (can && i != w) waitc[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic rand_op(input int i);
    set_op(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom),
              ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom),
              1'($urandom_range(0, 1)));
  endtask

  logic [W-1:0] held_sum;

  initial begin
    // Reset state
    #1;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_sum", rsp_sum, 0);
    chk("reset_cout", rsp_cout, 0);
    chk("reset_id", rsp_id, 0);
    req_valid = 4'b0001;
    #1;
    chk("reset_ready", req_ready, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single op
    set_op(0, 32'h0000_0001, 32'h0000_0002, 1'b1);
    req_valid = 4'b0001;
    step();
    chk("single_valid", rsp_valid, 1);
    chk("single_sum", rsp_sum, 32'h0000_0004);
    chk("single_cout", rsp_cout, 0);
    chk("single_id", rsp_id, 0);

    // Overflow on requesters 1 and 2 (pointer now at 1)
    req_valid = 4'b0010;
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    chk("ovf1_sum", rsp_sum, 32'h0000_0000);
    chk("ovf1_cout", rsp_cout, 1);
    chk("ovf1_id", rsp_id, 1);
    req_valid = 4'b0100;
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step();
    chk("ovf2_sum", rsp_sum, 32'hFFFF_FFFF);
    chk("ovf2_cout", rsp_cout, 1);
    chk("ovf2_id", rsp_id, 2);
    req_valid = '0;
    step();
    chk("drain_valid", rsp_valid, 0);

    // Round robin from a fresh reset
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'h8000_0000, 32'h8000_0000 + W'(i), 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, i % N);
    end
    chk("rr_last_sum", rsp_sum, 32'h0000_0000);
    chk("rr_last_cout", rsp_cout, 1);

    // Backpressure: result held, nothing accepted
    held_sum = rsp_sum;
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("bp_ready", req_ready, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_sum", rsp_sum, held_sum);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b0010);
    step();
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_id", rsp_id, 1);

    // Asynchronous reset with a result in flight and pointer at 2
    rst_n = 1'b0;
    #1;
    chk("async_valid", rsp_valid, 0);
    chk("async_ready", req_ready, 4'b0000);
    chk("async_id", rsp_id, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("post_reset_ready", req_ready, 4'b0001);
    step();
    chk("post_reset_id", rsp_id, 0);
    chk("post_reset_valid", rsp_valid, 1);

    // Random traffic; requesters mostly hold valid until served
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (last_hs[i]) begin
            if ($urandom_range(0, 3) != 0) rand_op(i);
            else req_valid[i] = 1'b0;
          end else if ($urandom_range(0, 49) == 0) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          rand_op(i);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk("final_idle", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
